// File: rtl/pm_lcd_pkg.sv
// Shared LCD bus constants and copier state encoding.
// Imported by every PRC LCD bus master.
package pm_lcd_pkg;

  localparam logic [23:0] LCD_CMD_ADDR  = 24'h0020FE;
  localparam logic [23:0] LCD_DATA_ADDR = 24'h0020FF;

  localparam logic [7:0] CMD_SET_PAGE = 8'hB0;
  localparam logic [7:0] CMD_COL_LO   = 8'h00;
  localparam logic [7:0] CMD_COL_HI   = 8'h10;

  typedef enum logic [3:0] {
    S_IDLE,
    S_REQ,
    S_CMD_PAGE,
    S_CMD_LO,
    S_CMD_HI,
    S_RD,
    S_CAP,
    S_WR,
    S_DONE
  } copier_state_t;

endpackage

// File: rtl/prc_lcd_copier.sv
// Framebuffer-to-LCD copier: owns the CPU bus and streams
// page/column commands followed by one page of bytes at a time.
module prc_lcd_copier
  import pm_lcd_pkg::*;
#(
  parameter logic [23:0] FB_BASE = 24'h001000,
  parameter int          COLUMNS = 96,
  parameter int          PAGES   = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_ce,
  input  logic        start,
  input  logic        abort,
  input  logic        bus_ack,
  output logic        bus_req,
  output logic [23:0] address_out,
  output logic [7:0]  data_out,
  input  logic [7:0]  data_in,
  output logic        bus_read,
  output logic        bus_write,
  output logic        busy,
  output logic        done
);

  localparam int CW = $clog2(COLUMNS);
  localparam int PW = (PAGES > 1) ? $clog2(PAGES) : 1;
  localparam logic [CW-1:0] COL_LAST  = CW'(COLUMNS - 1);
  localparam logic [PW-1:0] PAGE_LAST = PW'(PAGES - 1);

  copier_state_t r_state, w_state_nxt;
  logic          r_phase, w_phase_nxt;
  logic [PW-1:0] r_page, w_page_nxt;
  logic [CW-1:0] r_col, w_col_nxt;
  logic [7:0]    r_data;
  logic [7:0]    r_dout;
  logic [23:0]   r_addr;
  logic          w_wr_st;
  logic          w_active;
  logic [23:0]   w_waddr;
  logic [23:0]   w_raddr;
  logic [7:0]    w_wdata;

  assign w_wr_st = (r_state == S_CMD_PAGE) ||
                   (r_state == S_CMD_LO) ||
                   (r_state == S_CMD_HI) ||
                   (r_state == S_WR);
  assign w_active = (r_state != S_IDLE) &&
                    (r_state != S_DONE);

  always_comb begin
    w_state_nxt = r_state;
    w_phase_nxt = r_phase;
    w_page_nxt  = r_page;
    w_col_nxt   = r_col;
    if (abort && w_active) begin
      w_state_nxt = S_IDLE;
      w_phase_nxt = 1'b0;
    end else if (!w_active) begin
      // DONE re-arms directly so a held start gives back-to-back frames
      if (start) begin
        w_state_nxt = S_REQ;
        w_page_nxt  = '0;
      end else begin
        w_state_nxt = S_IDLE;
      end
    end else if (bus_ack) begin
      if (w_wr_st && !r_phase) begin
        w_phase_nxt = 1'b1;
      end else begin
        w_phase_nxt = 1'b0;
        unique case (r_state)
          S_REQ:      w_state_nxt = S_CMD_PAGE;
          S_CMD_PAGE: w_state_nxt = S_CMD_LO;
          S_CMD_LO:   w_state_nxt = S_CMD_HI;
          S_CMD_HI: begin
            w_state_nxt = S_RD;
            w_col_nxt   = '0;
          end
          S_RD:       w_state_nxt = S_CAP;
          S_CAP:      w_state_nxt = S_WR;
          S_WR: begin
            if (r_col < COL_LAST) begin
              w_col_nxt   = r_col + CW'(1);
              w_state_nxt = S_RD;
            end else if (r_page < PAGE_LAST) begin
              w_page_nxt  = r_page + PW'(1);
              w_state_nxt = S_CMD_PAGE;
            end else begin
              w_state_nxt = S_DONE;
            end
          end
          default:    w_state_nxt = S_IDLE;
        endcase
      end
    end
  end

  assign w_raddr = FB_BASE + 24'(r_page) * 24'(COLUMNS)
                 + 24'(r_col);
  assign w_waddr = (r_state == S_WR) ? LCD_DATA_ADDR
                                     : LCD_CMD_ADDR;

  always_comb begin
    w_wdata = r_data;
    if (r_state == S_CMD_PAGE)
      w_wdata = CMD_SET_PAGE | 8'(r_page);
    else if (r_state == S_CMD_LO)
      w_wdata = CMD_COL_LO;
    else if (r_state == S_CMD_HI)
      w_wdata = CMD_COL_HI;
  end

  // strobes are gated by the live grant so a lost bus sees nothing
  assign bus_write = w_wr_st && !r_phase && bus_ack;
  assign bus_read  = (r_state == S_RD) && bus_ack;
  assign address_out = bus_write ? w_waddr :
                       bus_read  ? w_raddr : r_addr;
  assign data_out = bus_write ? w_wdata : r_dout;
  assign bus_req  = w_active;
  assign busy     = w_active;
  assign done     = (r_state == S_DONE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_phase <= 1'b0;
      r_page  <= '0;
      r_col   <= '0;
      r_data  <= '0;
      r_addr  <= '0;
      r_dout  <= '0;
    end else if (clk_ce) begin
      r_state <= w_state_nxt;
      r_phase <= w_phase_nxt;
      r_page  <= w_page_nxt;
      r_col   <= w_col_nxt;
      r_addr  <= address_out;
      r_dout  <= data_out;
      if (r_state == S_CAP && bus_ack)
        r_data <= data_in;
    end
  end

endmodule

// File: tb/tb_prc_lcd_copier.sv
// Directed bench for prc_lcd_copier with a RAM model and an
// LCD write scoreboard.
module tb_prc_lcd_copier;

  logic        clk = 1'b0;
  logic        reset;
  logic        clk_ce;
  logic        start;
  logic        abort;
  logic        bus_ack;
  logic        bus_req;
  logic [23:0] address_out;
  logic [7:0]  data_out;
  logic [7:0]  data_in = 8'h00;
  logic        bus_read;
  logic        bus_write;
  logic        busy;
  logic        done;

  prc_lcd_copier dut (
    .clk         (clk),
    .reset       (reset),
    .clk_ce      (clk_ce),
    .start       (start),
    .abort       (abort),
    .bus_ack     (bus_ack),
    .bus_req     (bus_req),
    .address_out (address_out),
    .data_out    (data_out),
    .data_in     (data_in),
    .bus_read    (bus_read),
    .bus_write   (bus_write),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  logic [7:0]  mem [0:767];
  logic [31:0] sb [$];

  int cyc = 0;
  int wr_pulses = 0;
  int wr_back = 0;
  int overlap = 0;
  int extra_wr = 0;
  int gap_strobes = 0;
  int done_cnt = 0;
  int done_cyc = 0;
  int req_cyc = 0;
  logic        gap = 1'b0;
  logic        prev_wr = 1'b0;
  logic        prev_req = 1'b0;
  logic [31:0] first_wr = '0;
  logic [23:0] off;
  logic [31:0] exp_wr;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed %0h required %0h",
                tag, obs, exp);
  endtask

  task automatic push_frame();
    for (int p = 0; p < 8; p++) begin
      sb.push_back({24'h0020FE, 8'hB0 | 8'(p)});
      sb.push_back({24'h0020FE, 8'h00});
      sb.push_back({24'h0020FE, 8'h10});
      for (int c = 0; c < 96; c++)
        sb.push_back({24'h0020FF, 8'(p * 96 + c)});
    end
  endtask

  // bus/LCD model: RAM read response and LCD write scoreboard
  always @(negedge clk) begin
    cyc++;
    if (!reset) begin
      if (bus_write && prev_wr) wr_back++;
      if (bus_write && bus_read) overlap++;
      if (gap && (bus_write || bus_read)) gap_strobes++;
      if (bus_write) begin
        if (wr_pulses == 0)
          first_wr = {address_out, data_out};
        wr_pulses++;
        if (sb.size() == 0) begin
          extra_wr++;
        end else begin
          exp_wr = sb.pop_front();
          chk("lcd_write", {address_out, data_out}, exp_wr);
        end
      end
      if (bus_read) begin
        off = address_out - 24'h001000;
        data_in = (off < 24'd768) ? mem[off[9:0]] : 8'h00;
      end
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (bus_req && !prev_req) req_cyc = cyc;
    end
    prev_wr  = bus_write;
    prev_req = bus_req;
  end

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_strobe(input logic rd,
                             input logic [23:0] a,
                             input logic use_d,
                             input logic [7:0] d,
                             input int budget,
                             output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk); #1;
      if (rd ? (bus_read && address_out == a)
             : (bus_write && address_out == a &&
                (!use_d || data_out == d))) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  bit ok;
  int d0;
  int d1;

  initial begin
    reset = 1'b1;
    clk_ce = 1'b1;
    start = 1'b0;
    abort = 1'b0;
    bus_ack = 1'b1;
    for (int i = 0; i < 768; i++) mem[i] = 8'(i);
    repeat (3) @(posedge clk);
    #1;
    chk("rst_bus_req", 32'(bus_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_bus_write", 32'(bus_write), 32'd0);
    chk("rst_bus_read", 32'(bus_read), 32'd0);
    chk("rst_address", 32'(address_out), 32'd0);
    chk("rst_data", 32'(data_out), 32'd0);
    reset = 1'b0;

    // full frame with continuous grant
    @(posedge clk); #1;
    wr_pulses = 0;
    push_frame();
    pulse_start();
    chk("busy_after_start", 32'(busy), 32'd1);
    chk("req_after_start", 32'(bus_req), 32'd1);
    wait_done(4000, ok);
    chk("frame1_done_seen", 32'(ok), 32'd1);
    chk("frame1_len", 32'(done_cyc - req_cyc), 32'd3121);
    chk("frame1_sb_empty", 32'(sb.size()), 32'd0);
    chk("frame1_pulses", 32'(wr_pulses), 32'd792);
    chk("frame1_first_wr", first_wr, 32'h0020FEB0);
    chk("no_back_to_back_wr", 32'(wr_back), 32'd0);
    chk("no_rd_wr_overlap", 32'(overlap), 32'd0);
    chk("no_extra_wr", 32'(extra_wr), 32'd0);
    @(posedge clk); #1;
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_done", 32'(done), 32'd0);

    // grant loss at page 3 column 40, write phase 0
    wr_pulses = 0;
    push_frame();
    pulse_start();
    wait_strobe(1'b1, 24'h001000 + 24'd328, 1'b0, 8'h00,
                4000, ok);
    chk("gap_read_seen", 32'(ok), 32'd1);
    @(posedge clk);
    @(posedge clk); #1;
    bus_ack = 1'b0;
    gap = 1'b1;
    @(negedge clk); #1;
    chk("gap_req_held", 32'(bus_req), 32'd1);
    chk("gap_wr_low", 32'(bus_write), 32'd0);
    repeat (10) @(posedge clk);
    #1;
    bus_ack = 1'b1;
    gap = 1'b0;
    wait_done(4000, ok);
    chk("gap_done_seen", 32'(ok), 32'd1);
    chk("gap_frame_len", 32'(done_cyc - req_cyc), 32'd3131);
    chk("gap_no_strobes", 32'(gap_strobes), 32'd0);
    chk("gap_sb_empty", 32'(sb.size()), 32'd0);
    chk("gap_pulses", 32'(wr_pulses), 32'd792);

    // abort at page 5, then recopy from page 0
    @(posedge clk); #1;
    push_frame();
    pulse_start();
    wait_strobe(1'b0, 24'h0020FE, 1'b1, 8'hB5, 4000, ok);
    chk("abort_page5_seen", 32'(ok), 32'd1);
    @(posedge clk); #1;
    abort = 1'b1;
    d0 = done_cnt;
    @(posedge clk); #1;
    abort = 1'b0;
    sb.delete();
    chk("abort_req", 32'(bus_req), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_wr", 32'(bus_write), 32'd0);
    repeat (5) @(posedge clk);
    #1;
    chk("abort_no_done", 32'(done_cnt - d0), 32'd0);
    wr_pulses = 0;
    push_frame();
    pulse_start();
    wait_done(4000, ok);
    chk("recopy_done_seen", 32'(ok), 32'd1);
    chk("recopy_first_wr", first_wr, 32'h0020FEB0);
    chk("recopy_sb_empty", 32'(sb.size()), 32'd0);

    // reset during WR phase 0 while clk_ce is low
    @(posedge clk); #1;
    push_frame();
    pulse_start();
    wait_strobe(1'b0, 24'h0020FF, 1'b0, 8'h00, 4000, ok);
    chk("rst_wr_seen", 32'(ok), 32'd1);
    d0 = done_cnt;
    clk_ce = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    chk("midrst_wr", 32'(bus_write), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_req", 32'(bus_req), 32'd0);
    chk("midrst_addr", 32'(address_out), 32'd0);
    reset = 1'b0;
    clk_ce = 1'b1;
    sb.delete();
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_done", 32'(done_cnt - d0), 32'd0);

    // start held high: back-to-back frames
    push_frame();
    push_frame();
    start = 1'b1;
    wait_done(4000, ok);
    chk("b2b_done1_seen", 32'(ok), 32'd1);
    d1 = done_cyc;
    @(posedge clk); #1;
    start = 1'b0;
    chk("b2b_rearm_busy", 32'(busy), 32'd1);
    wait_done(4000, ok);
    chk("b2b_done2_seen", 32'(ok), 32'd1);
    chk("b2b_period", 32'(done_cyc - d1), 32'd3122);
    chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
    @(posedge clk); #1;
    chk("b2b_idle_busy", 32'(busy), 32'd0);
    chk("all_no_back_to_back", 32'(wr_back), 32'd0);
    chk("all_no_overlap", 32'(overlap), 32'd0);
    chk("all_no_extra_wr", 32'(extra_wr), 32'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/prc_lcd_copier.md
Name: prc_lcd_copier

Overview:
DMA-style sequencer that copies the 96x64 1bpp framebuffer in system RAM to the LCD controller, one 8-px page at a time.
- Requests the system bus from the CPU arbiter.
- Per page, issues page/column commands to 0x20FE, then 96 data writes to 0x20FF.
- Sits between the PRC frame timer (start) and the shared CPU bus.

Parameters:
FB_BASE, 24'h001000, framebuffer base address; byte for (page p, column c) is at FB_BASE + p*COLUMNS + c
COLUMNS, 96, data bytes written per page
PAGES, 8, pages per frame (0..PAGES-1)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
clk_ce  in  1  clock enable; all state advances only on clk edges with clk_ce=1
start  in  1  level-sampled frame copy request
abort  in  1  cancel copy in progress
bus_ack  in  1  arbiter grant; bus owned while high
bus_req  out  1  bus request
address_out  out  24  bus address
data_out  out  8  write data
data_in  in  8  read data; valid on the ce cycle after bus_read
bus_read  out  1  read strobe
bus_write  out  1  write strobe
busy  out  1  high from start accept until DONE/abort
done  out  1  one-ce-period pulse after the last byte

Behaviour:
- Reset is sampled on every posedge clk, independent of clk_ce.
  - State returns to IDLE; page and column counters clear.
  - All outputs go to 0: bus_req, bus_read, bus_write, busy, done, address_out, data_out.
  - Reset mid-copy abandons the frame with no done; strobes drop on the same edge.
- Strobe rule: the LCD controller edge-detects its strobes.
  - Every bus_write is high for exactly 1 ce cycle, then low for at least 1 ce cycle.
  - bus_read is high for exactly 1 ce cycle.
  - bus_read and bus_write are never high together.
- States:
  - IDLE: start=1 -> REQ; busy=1, bus_req=1, page=0.
  - REQ: wait for bus_ack=1 -> CMD_PAGE.
  - CMD_PAGE: write 8'hB0|page to 24'h20FE.
  - CMD_LO: write 8'h00 to 24'h20FE.
  - CMD_HI: write 8'h10 to 24'h20FE; col=0.
  - RD: bus_read=1, address_out = FB_BASE + page*COLUMNS + col (24-bit add, no wrap check).
  - CAP: latch data_in into the data register.
  - WR: write the latched byte to 24'h20FF.
  - NEXT:
    - If col < COLUMNS-1: col++ -> RD.
    - Else if page < PAGES-1: page++ -> CMD_PAGE.
    - Else -> DONE.
  - DONE: done=1, busy=0, bus_req=0 for one ce period -> IDLE.
- Each write state takes 2 ce cycles: phase 0 asserts bus_write with address/data; phase 1 deasserts bus_write and holds address/data.
- Latency: 1 ce in REQ once granted.
  - Per page: 6 ce for the three commands + 4*COLUMNS ce for data (RD, CAP, WR x2).
  - NEXT is folded into the last WR phase and costs no extra cycle.
  - Default frame: 8*(6+384) = 3120 ce cycles from first grant to DONE.
- Loss of grant: if bus_ack=0 in any post-REQ state, the state and phase hold.
  - bus_read/bus_write are forced 0 and bus_req stays 1.
  - Progress resumes at the held phase when bus_ack returns.
  - A write phase 0 interrupted by loss of grant re-issues a full pulse.
- abort=1 (any busy state): next ce -> IDLE, bus_req=0, busy=0, strobes 0, no done. Ignored in IDLE.
- start while busy: ignored.
- start held high through DONE: a new frame begins on the ce cycle after DONE.
- abort and start in the same IDLE cycle: start wins, because abort is ignored in IDLE.
- address_out and data_out hold their last values while strobes are low. They are don't-care for the bus but deterministic for the bench.

Decomposition:
- Shared package pm_lcd_pkg holds:
  - constants LCD_CMD_ADDR=24'h20FE and LCD_DATA_ADDR=24'h20FF;
  - command opcodes CMD_SET_PAGE=8'hB0, CMD_COL_LO=8'h00, CMD_COL_HI=8'h10;
  - copier_state_t enum.
- Optional sub-module bus_write_pulser: the 2-phase strobe generator with grant gating, reusable by other bus masters. Everything else stays in one module.

Test Plan:
- Reset, then start=1 with bus_ack=1 and FB filled with byte (p*96+c)&8'hFF -> a model of the LCD controller receives B0,00,10 then 00..5F for page 0; B7,00,10 for page 7; done after 3120 ce; busy=0.
- Strobe check over a full frame -> no consecutive-cycle bus_write highs, no read/write overlap, and 8*(3+96)=792 write pulses total.
- Drop bus_ack for 10 ce at page 3, col 40, write phase 0 -> no strobes during the gap; after the gap, byte 40 is written exactly once; frame ends 10 ce late.
- abort at page 5 -> IDLE next ce, bus_req=0, no done. A following start recopies from page 0 (first write is B0).
- Reset asserted mid-WR phase 0 with clk_ce=0 -> bus_write=0 and busy=0 on the next clk edge.
- start held high continuously -> back-to-back frames, with done pulses 3122 ce apart (3120 copy + 1 DONE + 1 REQ).
